// File: rtl/btn_pkg.sv
// Shared types and limits for the button event arbiter.
// Optional feature macro: BTN_OVERRUN_EN (adds the sticky overrun flag).
package btn_pkg;

    localparam int unsigned N_BTN_MAX   = 8;
    localparam int unsigned GAP_CYC_MAX = 255;
    localparam int unsigned GAP_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } arb_state_e;

    // Event code width for n channels; never narrower than one bit.
    function automatic int unsigned code_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_rr_pick.sv
// Combinational round-robin finder: first set request above last_grant, wrapping.
module btn_rr_pick
    import btn_pkg::*;
#(
    parameter  int unsigned N_BTN  = 5,
    localparam int unsigned CODE_W = code_width(N_BTN)
) (
    input  logic [N_BTN-1:0]  req,
    input  logic [CODE_W-1:0] last_grant,
    output logic [CODE_W-1:0] winner,
    output logic              any
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner = '0;
        idx    = 0;
        any    = |req;
        for (int unsigned k = N_BTN; k >= 1; k--) begin
            idx = 32'(last_grant) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (req[CODE_W'(idx)]) begin
                winner = CODE_W'(idx);
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Serialises debounced button release pulses into a valid/ready event stream,
// round-robin among pending buttons, with an enforced gap after each accept.
// Optional feature macro: BTN_OVERRUN_EN (sticky overrun output).
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter  int unsigned N_BTN   = 5,
    parameter  int unsigned GAP_CYC = 4,
    localparam int unsigned CODE_W  = code_width(N_BTN)
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic [N_BTN-1:0]  btn_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic [N_BTN-1:0]  pend
`ifdef BTN_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);

    arb_state_e        state;
    logic [CODE_W-1:0] last_grant;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
    logic [N_BTN-1:0]  clr_mask;
    logic [CODE_W-1:0] rr_winner;
    logic              rr_any;

    // Handshake completes only while an event is presented.
    always_comb begin
        accept   = evt_valid & evt_ready;
        clr_mask = accept ? (N_BTN'(1) << evt_code) : '0;
    end

    btn_rr_pick #(
        .N_BTN (N_BTN)
    ) u_pick (
        .req        (pend),
        .last_grant (last_grant),
        .winner     (rr_winner),
        .any        (rr_any)
    );

    // Pending flags: a new pulse always wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | btn_pulse;
        end
    end

`ifdef BTN_OVERRUN_EN
    // Sticky flag for a pulse landing on a flag that is still pending.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (|(btn_pulse & pend & ~clr_mask)) begin
            overrun <= 1'b1;
        end
    end
`endif

    // Arbitration FSM with registered valid/code, grant pointer and gap counter.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            last_grant <= CODE_W'(N_BTN - 1);
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        evt_code  <= rr_winner;
                        evt_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        evt_valid  <= 1'b0;
                        last_grant <= evt_code;
                        if (GAP_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
